// File: rtl/stream_ppfifo_writer.sv
// Writes a valid/ready word stream into one half of a ping-pong FIFO at a time.
// A buffer is released when it is full, on end-of-packet, or after an idle timeout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no buffer held; grant the first ready buffer
// ST_FILL    | buffer activated; accept words until full, last or timeout
// ST_RELEASE | one cycle hold so the final strobe lands while activated
module stream_ppfifo_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_ready,
    input  logic [1:0]            i_wr_rdy,
    output logic [1:0]            o_wr_act,
    input  logic [15:0]           i_wr_size,
    output logic                  o_wr_stb,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [15:0]           o_count,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RELEASE
    } state_t;

    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT);

    state_t                state_q, state_d;
    logic [1:0]            act_q, act_d;
    logic                  stb_q, stb_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           size_q, size_d;
    logic [15:0]           tmr_q, tmr_d;
    logic                  handshake;

    assign o_ready   = (state_q == ST_FILL) && (count_q < size_q);
    assign o_busy    = (state_q != ST_IDLE);
    assign o_wr_act  = act_q;
    assign o_wr_stb  = stb_q;
    assign o_wr_data = data_q;
    assign o_count   = count_q;
    assign handshake = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        stb_d   = 1'b0;
        data_d  = data_q;
        count_d = count_q;
        size_d  = size_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wr_rdy != 2'b00) begin
                    state_d = ST_FILL;
                    act_d   = i_wr_rdy[0] ? 2'b01 : 2'b10;
                    size_d  = i_wr_size;
                    count_d = 16'd0;
                    tmr_d   = TMR_LOAD;
                end
            end
            ST_FILL: begin
                if (size_q == 16'd0) begin
                    state_d = ST_RELEASE;
                end else if (handshake) begin
                    stb_d   = 1'b1;
                    data_d  = i_data;
                    count_d = count_q + 16'd1;
                    tmr_d   = TMR_LOAD;
                    if ((count_q + 16'd1) == size_q || i_last) begin
                        state_d = ST_RELEASE;
                    end
                end else if (count_q != 16'd0 && TIMEOUT != 0) begin
                    // Down-counter: the edge that would take it to zero is the timeout edge.
                    if (tmr_q <= 16'd1) begin
                        state_d = ST_RELEASE;
                    end else begin
                        tmr_d = tmr_q - 16'd1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                act_d   = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                act_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            act_q   <= 2'b00;
            stb_q   <= 1'b0;
            data_q  <= '0;
            count_q <= 16'd0;
            size_q  <= 16'd0;
            tmr_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            stb_q   <= stb_d;
            data_q  <= data_d;
            count_q <= count_d;
            size_q  <= size_d;
            tmr_q   <= tmr_d;
        end
    end

endmodule

// File: tb/tb_stream_ppfifo_writer.sv
// Bench for stream_ppfifo_writer: directed buffer scenarios plus random traffic,
// all checked in lockstep against a transaction-level model of the writer.
module tb_stream_ppfifo_writer;

    localparam int TO = 8;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_last;
    logic        o_ready;
    logic [1:0]  i_wr_rdy;
    logic [1:0]  o_wr_act;
    logic [15:0] i_wr_size;
    logic        o_wr_stb;
    logic [31:0] o_wr_data;
    logic [15:0] o_count;
    logic        o_busy;

    stream_ppfifo_writer #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_ready   (o_ready),
        .i_wr_rdy  (i_wr_rdy),
        .o_wr_act  (o_wr_act),
        .i_wr_size (i_wr_size),
        .o_wr_stb  (o_wr_stb),
        .o_wr_data (o_wr_data),
        .o_count   (o_count),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 = no buffer, 1 = filling, 2 = release hold.
    int          m_phase = 0;
    logic [1:0]  m_act   = 2'b00;
    logic        m_stb   = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_count = 0;
    int          m_size  = 0;
    int          m_idle  = 0;

    int          n_stb, n_act, n_rdy;
    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (m_phase == 1) && (m_count < m_size);
    endfunction

    task automatic model_edge(input logic v, input logic [31:0] d, input logic l,
                              input logic [1:0] rdy, input logic [15:0] sz, input logic rst);
        bit can_take;
        can_take = model_ready();
        m_stb = 1'b0;
        if (rst) begin
            m_phase = 0; m_act = 2'b00; m_data = '0; m_count = 0; m_idle = 0;
        end else if (m_phase == 0) begin
            if (rdy != 2'b00) begin
                m_phase = 1;
                m_act   = rdy[0] ? 2'b01 : 2'b10;
                m_size  = int'(sz);
                m_count = 0;
                m_idle  = 0;
            end
        end else if (m_phase == 1) begin
            if (m_size == 0) begin
                m_phase = 2;
            end else if (v && can_take) begin
                m_stb = 1'b1;
                m_data = d;
                m_count++;
                m_idle = 0;
                if (m_count == m_size || l) m_phase = 2;
            end else if (m_count > 0) begin
                if (m_idle < 65535) m_idle++;
                if (TO != 0 && m_idle == TO) m_phase = 2;
            end
        end else begin
            m_phase = 0;
            m_act   = 2'b00;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic [1:0] rdy, input logic [15:0] sz, input logic rst);
        i_valid = v; i_data = d; i_last = l; i_wr_rdy = rdy; i_wr_size = sz; i_rst = rst;
        #1;
        check("ready", o_ready, model_ready());
        check("busy", o_busy, m_phase != 0);
        if (o_ready) n_rdy++;
        @(posedge i_clk);
        model_edge(v, d, l, rdy, sz, rst);
        #1;
        check("act", o_wr_act, m_act);
        check("stb", o_wr_stb, m_stb);
        check("data", o_wr_data, m_data);
        check("count", o_count, m_count);
        if (o_wr_stb) begin
            n_stb++;
            sb.push_back(o_wr_data);
        end
        if (o_wr_act != 2'b00) n_act++;
    endtask

    task automatic clear_stats();
        n_stb = 0; n_act = 0; n_rdy = 0;
        sb.delete();
    endtask

    task automatic drive_words(input int n, input int base, input bit last_final,
                               input logic [1:0] rdy, input logic [15:0] sz, input int budget);
        int w = 0;
        int c = 0;
        bit hs;
        while (w < n && c < budget) begin
            hs = model_ready();
            step(1'b1, 32'(base + w), last_final && (w == n - 1), rdy, sz, 1'b0);
            if (hs) w++;
            c++;
        end
        check("words_accepted", w, n);
    endtask

    task automatic settle();
        int c = 0;
        while (m_phase != 0 && c < 40) begin
            step(1'b0, 32'd0, 1'b0, 2'b00, 16'd0, 1'b0);
            c++;
        end
        check("settle_idle", m_phase, 0);
    endtask

    initial begin
        int drop;
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
        i_wr_rdy = 2'b00; i_wr_size = 16'd0;
        @(posedge i_clk);
        #1;
        step(1'b0, 32'd0, 1'b0, 2'b11, 16'd4, 1'b1);
        check("rst_act", o_wr_act, 2'b00);
        check("rst_count", o_count, 16'd0);

        // Full buffer of 16, then the second buffer.
        clear_stats();
        drive_words(16, 0, 1'b0, 2'b11, 16'd16, 60);
        settle();
        check("s1_count", o_count, 16'd16);
        check("s1_nstb", n_stb, 16);
        for (int i = 0; i < sb.size(); i++) check("s1_data", sb[i], 32'(i));

        clear_stats();
        drive_words(16, 16, 1'b0, 2'b10, 16'd16, 60);
        settle();
        check("s2_count", o_count, 16'd16);
        for (int i = 0; i < sb.size(); i++) check("s2_data", sb[i], 32'(16 + i));

        // Early end-of-packet.
        clear_stats();
        drive_words(5, 50, 1'b1, 2'b01, 16'd16, 30);
        settle();
        check("s3_nstb", n_stb, 5);
        check("s3_count", o_count, 16'd5);

        // Idle timeout after three words.
        drive_words(3, 100, 1'b0, 2'b01, 16'd16, 20);
        drop = -1;
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 32'd0, 1'b0, 2'b00, 16'd0, 1'b0);
            if (drop < 0 && o_wr_act == 2'b00) drop = k;
        end
        check("s4_release_lat", drop, 9);
        check("s4_count", o_count, 16'd3);

        // Empty buffer is held indefinitely.
        step(1'b0, 32'd0, 1'b0, 2'b01, 16'd16, 1'b0);
        for (int k = 0; k < 100; k++) step(1'b0, 32'd0, 1'b0, 2'b00, 16'd0, 1'b0);
        check("s4_hold_act", o_wr_act, 2'b01);
        drive_words(1, 200, 1'b1, 2'b00, 16'd16, 5);
        settle();

        // Zero-size grant.
        clear_stats();
        step(1'b1, 32'd7, 1'b0, 2'b01, 16'd0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 32'd7, 1'b0, 2'b00, 16'd0, 1'b0);
        check("s5_act_cycles", n_act, 2);
        check("s5_nstb", n_stb, 0);
        check("s5_ready_cycles", n_rdy, 0);

        // Reset mid-fill, then a fresh buffer.
        drive_words(7, 300, 1'b0, 2'b01, 16'd16, 20);
        step(1'b1, 32'd0, 1'b0, 2'b00, 16'd0, 1'b1);
        check("s6_rst_act", o_wr_act, 2'b00);
        check("s6_rst_count", o_count, 16'd0);
        clear_stats();
        drive_words(16, 400, 1'b0, 2'b10, 16'd16, 40);
        settle();
        check("s6_count", o_count, 16'd16);
        check("s6_nstb", n_stb, 16);

        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 8) == 0,
                 2'($urandom_range(0, 3)), 16'($urandom_range(0, 20)),
                 ($urandom % 250) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
